// File: rtl/pi_digit_reader.sv
`default_nettype none
// pi_digit_reader: reads base-1000 limbs from the result RAM, MSB limb first, and
// streams them out as decimal symbols (digits 0-9, 4'hA for the decimal point).
module pi_digit_reader #(
    parameter int L        = 47,
    parameter int ADR_BITS = 6,
    parameter int N        = 10,
    parameter int RAMDELAY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADR_BITS-1:0] rdadd,
    input  logic [N-1:0]        rdq,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic [3:0]          sym,
    output logic [7:0]          sym_idx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CONV  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [N-1:0] bin;
    logic [11:0] bcd;
    logic [1:0]  pos;

    logic        int_limb, last_sym, xfer, fetch_end, conv_end, over;
    logic [3:0]  tens_adj, ones_adj;
    logic [11:0] bcd_shift;

    assign int_limb  = (rdadd == ADR_BITS'(L - 1));
    assign last_sym  = int_limb ? (pos == 2'd1) : (pos == 2'd2);
    assign xfer      = (state == EMIT) && sym_ready;
    assign fetch_end = (cnt == 8'(RAMDELAY - 1));
    assign conv_end  = (cnt == 8'(N - 1));
    assign over      = (32'(rdq) > 32'd999);

    assign sym_valid = (state == EMIT);
    assign busy      = (state == FETCH) || (state == CONV) || (state == EMIT);
    assign done      = (state == DONE);

    // The hundreds nibble never reaches 5 before the final shift (result <= 999),
    // so only tens and ones need the add-3 correction.
    always_comb begin
        tens_adj  = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        ones_adj  = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        bcd_shift = {bcd[10:8], tens_adj, ones_adj, bin[N-1]};
    end

    function automatic logic [3:0] pick(input logic [11:0] b, input logic [1:0] p,
                                        input logic il);
        logic [3:0] d;
        d = b[3:0];
        if (il) begin
            d = (p == 2'd0) ? b[3:0] : 4'hA;
        end else begin
            case (p)
                2'd0:    d = b[11:8];
                2'd1:    d = b[7:4];
                default: d = b[3:0];
            endcase
        end
        return d;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start)     state_nx = FETCH;
            FETCH:      if (fetch_end) state_nx = CONV;
            CONV:       if (conv_end)  state_nx = EMIT;
            EMIT: begin
                if (xfer && last_sym) state_nx = (rdadd == '0) ? DONE : FETCH;
            end
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdadd   <= '0;
            sym     <= 4'd0;
            sym_idx <= 8'd0;
            err     <= 1'b0;
            cnt     <= 8'd0;
            bin     <= '0;
            bcd     <= 12'd0;
            pos     <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rdadd   <= ADR_BITS'(L - 1);
                        sym_idx <= 8'd0;
                        err     <= 1'b0;
                        cnt     <= 8'd0;
                    end
                end
                FETCH: begin
                    if (fetch_end) begin
                        cnt <= 8'd0;
                        bcd <= 12'd0;
                        if (over) begin
                            bin <= N'(999);
                            err <= 1'b1;
                        end else begin
                            bin <= rdq;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CONV: begin
                    bcd <= bcd_shift;
                    bin <= {bin[N-2:0], 1'b0};
                    if (conv_end) begin
                        cnt <= 8'd0;
                        pos <= 2'd0;
                        sym <= pick(bcd_shift, 2'd0, int_limb);
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                EMIT: begin
                    if (sym_ready) begin
                        sym_idx <= sym_idx + 8'd1;
                        if (last_sym) begin
                            pos <= 2'd0;
                            cnt <= 8'd0;
                            if (rdadd != '0) rdadd <= rdadd - 1'b1;
                        end else begin
                            pos <= pos + 2'd1;
                            sym <= pick(bcd, pos + 2'd1, int_limb);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pi_digit_reader.sv
`default_nettype none
// Bench for pi_digit_reader: RAM model with two-cycle read latency and a symbol
// scoreboard filled from the RAM contents before each run.
module tb_pi_digit_reader;
    localparam int L        = 47;
    localparam int ADR_BITS = 6;
    localparam int N        = 10;
    localparam int RAMDELAY = 2;
    localparam int NSYM     = 2 + 3 * (L - 1);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                sym_ready = 1'b0;
    logic [ADR_BITS-1:0] rdadd;
    logic [N-1:0]        rdq;
    logic                sym_valid;
    logic [3:0]          sym;
    logic [7:0]          sym_idx;
    logic                busy, done, err;

    logic [N-1:0] mem [0:L-1];
    logic [N-1:0] ram_q;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_idx = 0;
    int   n_xfer = 0;
    logic [3:0] exp_q[$];

    pi_digit_reader #(.L(L), .ADR_BITS(ADR_BITS), .N(N), .RAMDELAY(RAMDELAY)) dut (
        .clk(clk), .rst(rst), .start(start), .rdadd(rdadd), .rdq(rdq),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym(sym), .sym_idx(sym_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered address inside the DUT plus one RAM stage gives RAMDELAY = 2.
    always @(posedge clk) ram_q <= mem[rdadd];
    assign rdq = ram_q;

    // Scoreboard: a transfer happens at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (sym_valid && sym_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got sym %h idx %0d, required no symbol", sym, sym_idx);
            end else begin
                if (sym !== exp_q[0] || sym_idx !== 8'(exp_idx)) begin
                    n_fail++;
                    $display("FAIL sb_symbol: got sym %h idx %0d, required sym %h idx %0d",
                             sym, sym_idx, exp_q[0], exp_idx);
                end
                void'(exp_q.pop_front());
            end
            exp_idx++;
            n_xfer++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_mem(input int limb45);
        for (int a = 0; a < L; a++) mem[a] = '0;
        mem[46] = N'(3);
        mem[45] = N'(limb45);
        mem[44] = N'(592);
    endtask

    task automatic push_expected();
        int v;
        exp_q.delete();
        exp_idx = 0;
        n_xfer  = 0;
        for (int a = L - 1; a >= 0; a--) begin
            v = (int'(mem[a]) > 999) ? 999 : int'(mem[a]);
            if (a == L - 1) begin
                exp_q.push_back(4'(v % 10));
                exp_q.push_back(4'hA);
            end else begin
                exp_q.push_back(4'(v / 100));
                exp_q.push_back(4'((v / 10) % 10));
                exp_q.push_back(4'(v % 10));
            end
        end
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({rdadd, sym_valid, sym, sym_idx, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, required 0",
                     {rdadd, sym_valid, sym, sym_idx, busy, done, err});
        end
        rst = 1'b1;
        tick();
        load_mem(141);
        exp_q.delete();
        sym_ready = 1'b1;
        pulse_start();
        repeat (RAMDELAY + 3) tick();
        n_cmp++;
        if (busy !== 1'b1 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midconv_pre: got busy %b valid %b, required 1 0", busy, sym_valid);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({rdadd, sym_valid, sym, sym_idx, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h, required 0",
                     {rdadd, sym_valid, sym, sym_idx, busy, done, err});
        end
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sym_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_no_valid: got activity 1, required 0");
        end
    endtask

    task automatic test_basic();
        int t45, t2;
        t45 = -1;
        t2  = -1;
        load_mem(141);
        push_expected();
        sym_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4000 && !done; i++) begin
            if (t45 < 0 && rdadd == 6'd45) t45 = cyc;
            if (t2 < 0 && sym_valid && sym_idx == 8'd2) t2 = cyc;
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || n_xfer != NSYM || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_count: got done %b xfers %0d left %0d, required 1 %0d 0",
                     done, n_xfer, exp_q.size(), NSYM);
        end
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0 || sym_valid !== 1'b0 || rdadd !== 6'd0) begin
            n_fail++;
            $display("FAIL basic_done_state: got err %b busy %b valid %b rdadd %0d, required 0 0 0 0",
                     err, busy, sym_valid, rdadd);
        end
        n_cmp++;
        if (sym_idx !== 8'(NSYM)) begin
            n_fail++;
            $display("FAIL basic_final_idx: got %0d, required %0d", sym_idx, NSYM);
        end
        n_cmp++;
        if (t45 < 0 || t2 < 0 || (t2 - t45) != RAMDELAY + 10) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, required %0d", t2 - t45, RAMDELAY + 10);
        end
    endtask

    task automatic test_backpressure();
        logic stalled;
        stalled = 1'b0;
        load_mem(141);
        push_expected();
        sym_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4000 && !done; i++) begin
            if (!stalled && sym_valid && sym_idx == 8'd3) begin
                sym_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    n_cmp++;
                    if (sym_valid !== 1'b1 || sym !== 4'd4 || sym_idx !== 8'd3) begin
                        n_fail++;
                        $display("FAIL bp_hold: got valid %b sym %h idx %0d, required 1 4 3",
                                 sym_valid, sym, sym_idx);
                    end
                end
                sym_ready = 1'b1;
                stalled = 1'b1;
            end
            tick();
        end
        n_cmp++;
        if (!stalled || done !== 1'b1 || n_xfer != NSYM || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got stalled %b done %b xfers %0d, required 1 1 %0d",
                     stalled, done, n_xfer, NSYM);
        end
    endtask

    task automatic test_start_ignored();
        logic pulsed;
        pulsed = 1'b0;
        load_mem(141);
        push_expected();
        sym_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4000 && !done; i++) begin
            if (!pulsed && sym_valid && sym_idx == 8'd50) begin
                pulse_start();
                pulsed = 1'b1;
                n_cmp++;
                if (busy !== 1'b1 || sym_idx < 8'd50) begin
                    n_fail++;
                    $display("FAIL ignore_start_busy: got busy %b idx %0d, required 1 >=50",
                             busy, sym_idx);
                end
            end
            tick();
        end
        n_cmp++;
        if (!pulsed || done !== 1'b1 || n_xfer != NSYM || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ignore_start_count: got pulsed %b done %b xfers %0d, required 1 1 %0d",
                     pulsed, done, n_xfer, NSYM);
        end
    endtask

    task automatic test_err();
        load_mem(1023);
        push_expected();
        sym_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4000 && !done; i++) tick();
        n_cmp++;
        if (done !== 1'b1 || n_xfer != NSYM || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL err_count: got done %b xfers %0d, required 1 %0d", done, n_xfer, NSYM);
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_flag: got %b, required 1", err);
        end
    endtask

    task automatic test_restart();
        load_mem(141);
        push_expected();
        sym_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || sym_idx !== 8'd0 || rdadd !== 6'd46) begin
            n_fail++;
            $display("FAIL restart_accept: got err %b done %b busy %b idx %0d rdadd %0d, required 0 0 1 0 46",
                     err, done, busy, sym_idx, rdadd);
        end
        for (int i = 0; i < 4000 && !done; i++) tick();
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || n_xfer != NSYM || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart_run: got done %b err %b xfers %0d, required 1 0 %0d",
                     done, err, n_xfer, NSYM);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_err();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pi_digit_reader.md
PI_DIGIT_READER -- requirements
Module: pi_digit_reader

Interface
REQ-001 SHALL have parameter L, default 47, number of base-1000 limbs in the result RAM.
REQ-002 SHALL have parameter ADR_BITS, default 6, limb address width.
REQ-003 SHALL have parameter N, default 10, limb data width.
REQ-004 SHALL have parameter RAMDELAY, default 2, cycles from address update to valid read data.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse: result RAM is final, begin readout.
REQ-008 rdadd  output  ADR_BITS  registered read address to result RAM (sum_rdadd_ctrl).
REQ-009 rdq  input  N  result RAM read data (sum_q); limb L-1 = integer part, L-2..0 = fraction, MSB first.
REQ-010 sym_valid  output  1  sym/sym_idx hold a symbol.
REQ-011 sym_ready  input  1  consumer accepts the symbol on a cycle with sym_valid=1.
REQ-012 sym  output  4  0-9 = decimal digit, 4'hA = decimal point.
REQ-013 sym_idx  output  8  symbol position, 0 = first.
REQ-014 busy  output  1  high from the start pulse until DONE.
REQ-015 done  output  1  high in DONE until the next accepted start.
REQ-016 err  output  1  sticky: some limb exceeded 999 during this run.

Function
REQ-017 SHALL use states IDLE, FETCH, CONV, EMIT, DONE.
REQ-018 IDLE/DONE: start=1 -> FETCH, rdadd<=L-1, sym_idx<=0, err<=0, busy<=1, done<=0.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 FETCH: rdq SHALL be captured on the RAMDELAY-th rising edge after the edge that updated rdadd, then -> CONV.
REQ-021 CONV: 3-digit BCD via shift-add-3 (double dabble), exactly N=10 cycles, then -> EMIT.
REQ-022 Captured value >999: err<=1, converted as 999.
REQ-023 Limb L-1: EMIT SHALL output only its ones digit, then 4'hA; fraction limbs output hundreds, tens, ones, in that order.
REQ-024 Handshake: a symbol is transferred on a rising edge with sym_valid=1 and sym_ready=1; sym and sym_idx SHALL stay stable while sym_valid=1 and sym_ready=0.
REQ-025 sym_valid SHALL be high throughout EMIT; sym_idx SHALL increment by 1 on each transfer.
REQ-026 After the last symbol of a limb transfers: rdadd=0 -> DONE, else rdadd<=rdadd-1 -> FETCH.
REQ-027 Full run SHALL produce exactly 2+3*(L-1) symbols (140 at L=47), indices 0..139.
REQ-028 Minimum cycles per fraction limb SHALL be RAMDELAY+10+3 with sym_ready held high.
REQ-029 DONE: busy=0, done=1, sym_valid=0, rdadd held at 0.
REQ-030 sym_idx arithmetic SHALL be 8-bit without wrap for L<=85.

Reset
REQ-031 rst=0 SHALL force, at any time and in any state, IDLE, rdadd=0, sym_valid=0, sym=0, sym_idx=0, busy=0, done=0, err=0.
REQ-032 Reset mid-run SHALL discard partial conversion; no symbol SHALL be presented until a new start after reset release.

Verification
REQ-033 Reset: assert rst=0 mid-CONV -> all outputs 0 on the same cycle, no sym_valid after release without start.
REQ-034 RAM model limbs[46]=3, [45]=141, [44]=592, others 0; start, sym_ready=1 -> symbols 3,A,1,4,1,5,9,2 then 0s, 140 total, idx 0..139, done=1, err=0.
REQ-035 Backpressure: sym_ready=0 for 5 cycles while idx=3 is presented -> sym=4 and idx=3 held, no loss or duplicate.
REQ-036 limbs[45]=1023 -> err=1, symbols 2..4 = 9,9,9, run completes at 140 symbols.
REQ-037 start pulse at idx 50 -> ignored, run completes normally; start in DONE -> new run from idx 0, err cleared.
REQ-038 Timing: sym_ready=1 -> first fraction symbol (idx 2) at exactly RAMDELAY+10 cycles after the limb-45 rdadd update.
